// File: rtl/ro_edge_counter_if.sv
// ----------------------------------------------------------------------------
// ro_edge_counter_if
//   Result handshake between ro_edge_counter (producer) and the downstream
//   UART packetiser (consumer).
//
//   count_out       CNT_W  edge count of the last completed window
//   count_overflow  1      accumulator saturated during that window
//   count_valid     1      count_out / count_overflow hold an unconsumed result
//   count_ready     1      consumer accepts when count_valid & count_ready
//
//   master : producer side (drives result + valid, samples ready)
//   slave  : consumer side (samples result + valid, drives ready)
// ----------------------------------------------------------------------------
interface ro_edge_counter_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] count_out;
  logic             count_overflow;
  logic             count_valid;
  logic             count_ready;

  modport master (
    output count_out,
    output count_overflow,
    output count_valid,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_overflow,
    input  count_valid,
    output count_ready
  );
endinterface : ro_edge_counter_if

// File: rtl/ro_edge_counter.sv
// ----------------------------------------------------------------------------
// ro_edge_counter
//   Counts rising edges of a free-running (prescaled) ring-oscillator signal
//   between successive window_done pulses, snapshots each window's count and
//   offers it downstream over a valid/ready handshake. Windows that close
//   while a previous result is still unconsumed are counted as dropped.
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     ro_in        ring-oscillator input, asynchronous to clk
//     window_done  single-cycle pulse closing the current window
//     res          result handshake (count_out, count_overflow,
//                  count_valid out; count_ready in)
//     dropped      saturating count of windows lost to back-pressure
//
//   A window is the set of clocks after one window_done up to and including
//   the next; an edge detected in the window_done cycle belongs to the
//   window being closed.
// ----------------------------------------------------------------------------
module ro_edge_counter #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ro_in,
  input  logic                  window_done,
  ro_edge_counter_if.master     res,
  output logic [DROP_W-1:0]     dropped
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser and rising-edge detect
  // --------------------------------------------------------------------------
  logic s1, s2, s3;
  logic rise;

  // NOTE: s1/s2 form a plain two-flop synchroniser; nothing but s2 may look at
  // s1, otherwise a metastable value leaks into the logic. s3 is an ordinary
  // delay stage used only for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the three stages shift in one clock;
      // blocking ones here would collapse the chain into a single flop.
      s1 <= ro_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // --------------------------------------------------------------------------
  // Edge accumulator with saturation flag
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] acc;
  logic             sat;
  logic             acc_max;
  logic [CNT_W-1:0] snap;
  logic             snap_ovf;

  assign acc_max  = (acc == {CNT_W{1'b1}});
  // The edge seen in the closing cycle is folded into the snapshot, since the
  // accumulator itself is cleared on that same edge.
  assign snap     = acc_max ? acc : acc + {{(CNT_W-1){1'b0}}, rise};
  assign snap_ovf = sat | (acc_max & rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (window_done) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (rise) begin
      if (acc_max) sat <= 1'b1;
      else         acc <= acc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output FSM: EMPTY holds no result, FULL holds one awaiting the handshake
  // --------------------------------------------------------------------------
  state_t state, state_next;
  logic   load;
  logic   drop_inc;
  logic   handshake;

  // count_ready has no effect while EMPTY because count_valid is low there.
  assign handshake = res.count_valid & res.count_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop_inc   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (window_done) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (window_done && handshake) begin
          // Old result leaves as the new one arrives: nothing is lost.
          load = 1'b1;
        end else if (window_done) begin
          // Consumer still holds off: the new window's result is discarded.
          drop_inc = 1'b1;
        end else if (handshake) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign res.count_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res.count_out      <= '0;
      res.count_overflow <= 1'b0;
    end else if (load) begin
      res.count_out      <= snap;
      res.count_overflow <= snap_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped <= '0;
    end else if (drop_inc && (dropped != {DROP_W{1'b1}})) begin
      dropped <= dropped + 1'b1;
    end
  end

endmodule : ro_edge_counter

// File: tb/tb_ro_edge_counter.sv
// ----------------------------------------------------------------------------
// tb_ro_edge_counter
//   Directed bench for ro_edge_counter. Two instances share clk, rst_n, ro_in
//   and window_done: dut16 (CNT_W = 16) carries most scenarios, dut8
//   (CNT_W = 8, always ready) shows saturation and that the overflow flag
//   clears on the following window. Inputs change 1 ns after the rising
//   clock edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ro_edge_counter;

  logic clk;
  logic rst_n;
  logic ro_in;
  logic window_done;
  logic ready16;
  logic ready8;
  logic [7:0] dropped16;
  logic [7:0] dropped8;

  // ro_in generator control: half period in clk cycles, 0 = hold ro_level
  int   ro_half;
  logic ro_level;

  int n_vec;
  int n_fail;

  ro_edge_counter_if #(.CNT_W(16)) if16 ();
  ro_edge_counter_if #(.CNT_W(8))  if8  ();

  assign if16.count_ready = ready16;
  assign if8.count_ready  = ready8;

  ro_edge_counter #(.CNT_W(16), .DROP_W(8)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ro_in       (ro_in),
    .window_done (window_done),
    .res         (if16),
    .dropped     (dropped16)
  );

  ro_edge_counter #(.CNT_W(8), .DROP_W(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .ro_in       (ro_in),
    .window_done (window_done),
    .res         (if8),
    .dropped     (dropped8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring-oscillator model: toggles every ro_half clocks, changing 2 ns after
  // the rising edge so it is never coincident with input drives or samples.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #2;
      if (ro_half == 0) begin
        ro_in = ro_level;
        phase = 0;
      end else begin
        phase++;
        if (phase >= ro_half) begin
          ro_in = ~ro_in;
          phase = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    n_vec++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Closes a window of len clocks counted from the current point; returns
  // 1 ns after the edge that sampled window_done.
  task automatic close_window(input int len);
    if (len > 1) cycles(len - 1);
    window_done = 1'b1;
    cycles(1);
    window_done = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    ro_in       = 1'b0;
    window_done = 1'b0;
    ready16     = 1'b0;
    ready8      = 1'b1;
    ro_half     = 0;
    ro_level    = 1'b0;

    // ---- reset state ------------------------------------------------------
    cycles(3);
    check("rst_count_out",  if16.count_out,      0);
    check("rst_overflow",   if16.count_overflow, 0);
    check("rst_valid",      if16.count_valid,    0);
    check("rst_dropped",    dropped16,           0);

    // ---- 1: period 4, 10_000-clk windows, always ready --------------------
    ready16 = 1'b1;
    ro_half = 2;
    rst_n   = 1'b1;
    close_window(10000);
    check("t1_w1_valid",    if16.count_valid,    1);
    check("t1_w1_count",    if16.count_out,      2500, 1);
    check("t1_w1_ovf",      if16.count_overflow, 0);
    check("t3_w1_count8",   if8.count_out,       255);
    check("t3_w1_ovf8",     if8.count_overflow,  1);
    cycles(1);
    check("t1_w1_valid_drop", if16.count_valid,  0);
    close_window(9999);
    check("t1_w2_valid",    if16.count_valid,    1);
    check("t1_w2_count",    if16.count_out,      2500, 1);
    check("t1_w2_dropped",  dropped16,           0);
    cycles(1);
    check("t1_w2_valid_drop", if16.count_valid,  0);

    // ---- 3: slower input, overflow flag must clear ------------------------
    ro_half = 50;
    close_window(9999);
    check("t3_w2_count8",   if8.count_out,       100, 1);
    check("t3_w2_ovf8",     if8.count_overflow,  0);
    check("t3_w2_count16",  if16.count_out,      100, 1);
    cycles(1);

    // ---- 2: held-low and held-high inputs ---------------------------------
    ro_half  = 0;
    ro_level = 1'b0;
    close_window(50);
    cycles(1);
    close_window(999);
    check("t2_low_count",   if16.count_out,      0);
    check("t2_low_ovf",     if16.count_overflow, 0);
    cycles(1);
    ro_level = 1'b1;
    close_window(999);
    check("t2_rise_count",  if16.count_out,      1);
    cycles(1);
    close_window(999);
    check("t2_high_count",  if16.count_out,      0);
    check("t2_high_ovf",    if16.count_overflow, 0);
    cycles(1);

    // ---- 4: back-pressure across four window_done pulses ------------------
    ro_half = 2;
    close_window(50);
    cycles(1);
    ready16 = 1'b0;
    close_window(100);
    check("t4_first_valid", if16.count_valid,    1);
    check("t4_first_count", if16.count_out,      25, 1);
    for (int i = 0; i < 3; i++) begin
      close_window(200);
      check($sformatf("t4_hold_count_%0d", i), if16.count_out, 25, 1);
      check($sformatf("t4_hold_valid_%0d", i), if16.count_valid, 1);
    end
    check("t4_dropped",     dropped16,           3);
    ready16 = 1'b1;
    cycles(1);
    ready16 = 1'b0;
    check("t4_valid_after_hs", if16.count_valid, 0);

    // ---- 5: handshake coincident with window_done -------------------------
    close_window(100);
    check("t5_full",        if16.count_valid,    1);
    cycles(399);
    ready16     = 1'b1;
    window_done = 1'b1;
    cycles(1);
    window_done = 1'b0;
    ready16     = 1'b0;
    check("t5_new_count",   if16.count_out,      100, 1);
    check("t5_valid_kept",  if16.count_valid,    1);
    check("t5_dropped",     dropped16,           3);
    ready16 = 1'b1;
    cycles(1);
    ready16 = 1'b0;
    check("t5_valid_after_hs", if16.count_valid, 0);

    // ---- 6: asynchronous reset mid-window with a result pending -----------
    close_window(100);
    check("t6_full",        if16.count_valid,    1);
    cycles(50);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count",   if16.count_out,      0);
    check("t6_rst_ovf",     if16.count_overflow, 0);
    check("t6_rst_valid",   if16.count_valid,    0);
    check("t6_rst_dropped", dropped16,           0);
    check("t6_rst_valid8",  if8.count_valid,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    close_window(6000);
    check("t6_post_valid",  if16.count_valid,    1);
    check("t6_post_count",  if16.count_out,      1500, 1);
    check("t6_post_dropped", dropped16,          0);
    ready16 = 1'b1;
    cycles(1);
    ready16 = 1'b0;

    // ---- dropped counter saturation ----------------------------------------
    for (int i = 0; i < 260; i++) close_window(2);
    check("sat_dropped",    dropped16,           255);
    check("sat_valid",      if16.count_valid,    1);
    ready16 = 1'b1;
    cycles(1);
    ready16 = 1'b0;
    check("sat_valid_after_hs", if16.count_valid, 0);
    check("sat_dropped_kept",   dropped16,        255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_ro_edge_counter

// File: doc/ro_edge_counter.md
Name: ro_edge_counter

Overview:
- Consumer end of the measurement-window pulse. Counts rising edges of the free-running ring-oscillator signal between successive `window_done` pulses.
- Snapshots each window's count and offers it through a valid/ready handshake to the downstream UART packetiser.
- Reports counter saturation and windows dropped under back-pressure.

Parameters:
- CNT_W, 16, width of edge accumulator and `count_out`; 16 covers 10_000-cycle windows at up to clk/2.
- DROP_W, 8, width of the dropped-window counter.

Ports:
- clk  input  1  system clock (100 MHz)
- rst_n  input  1  asynchronous active-low reset
- ro_in  input  1  ring-oscillator output (prescaled); asynchronous to clk
- window_done  input  1  single-cycle pulse marking end of a measurement window
- count_out  output  CNT_W  edge count of the last completed window
- count_overflow  output  1  accumulator saturated during the window reported in `count_out`
- count_valid  output  1  `count_out` / `count_overflow` hold a fresh, unconsumed result
- count_ready  input  1  downstream accepts the result when `count_valid` & `count_ready`
- dropped  output  DROP_W  windows lost because the previous result was not yet consumed; saturating

Behaviour:
- Reset (`rst_n` = 0, async): every register clears. Sync chain, accumulator, sat flag, `count_out`, `count_overflow`, `count_valid` and `dropped` all read 0. The partial window in progress is discarded.
- Synchroniser and edge detect:
  - `ro_in` passes through a 2-FF synchroniser (s1, s2), then one extra delay stage s3.
  - rise = s2 & ~s3. An `ro_in` edge produces rise 2-3 clk later.
  - `ro_in` high and low times must each be ≥ 2 clk; faster input aliases and is out of scope.
- Accumulator (acc, CNT_W bits), evaluated each clk:
  - On rise with acc < all-ones: acc += 1.
  - On rise with acc = all-ones: acc holds and sat is set.
- window_done = 1 (snapshot cycle):
  - snap = acc + rise, saturating to all-ones.
  - snap_ovf = sat | (acc = all-ones & rise).
  - acc is cleared to 0 and sat cleared, so the edge in this cycle belongs to the closing window.
  - A window is therefore exactly the clocks between two `window_done` pulses, inclusive of the second.
- Output FSM, 2 states:
  - EMPTY (`count_valid` = 0) on window_done: load `count_out` = snap and `count_overflow` = snap_ovf; go FULL. `count_valid` rises 1 cycle after the window_done cycle.
  - FULL (`count_valid` = 1): `count_out` / `count_overflow` are stable until the handshake.
  - FULL, handshake only: go EMPTY; `count_valid` = 0 next cycle.
  - FULL, handshake and window_done in the same cycle: load the new snap; stay FULL; `count_valid` remains 1; `dropped` is unchanged.
  - FULL, window_done with no handshake: new snap is discarded; `count_out` unchanged; `dropped` += 1, saturating at all-ones.
- `dropped` clears only on reset.
- `count_ready` is ignored while EMPTY.
- A first window after reset is a full window: acc runs from reset release to the first window_done.

Test Plan:
1. `ro_in` square wave, period 4 clk (2 high / 2 low); window_done every 10_000 clk; `count_ready` = 1 → each result `count_out` = 2500 ±1, `count_overflow` = 0, `count_valid` pulses 1 cycle after each window_done, `dropped` = 0.
2. `ro_in` held 0, then held 1, across 3 windows → every `count_out` = 0 (at most 1 for the 0→1 window), `count_overflow` = 0.
3. CNT_W = 8, `ro_in` period 4, window 10_000 → `count_out` = 255, `count_overflow` = 1. Next window with `ro_in` period 100 gives 100 ±1 and `count_overflow` = 0, proving the flag clears.
4. `count_ready` = 0 across 4 window_done pulses → `count_out` holds the first window's value, `count_valid` stays 1, `dropped` = 3. Then `count_ready` = 1 for 1 cycle → `count_valid` = 0 next cycle.
5. FULL state, `count_ready` = 1 in the exact window_done cycle → `count_out` updates to the new window's value the next cycle, `count_valid` stays 1, `dropped` unchanged.
6. `rst_n` pulsed low mid-window with `count_valid` = 1 → all outputs 0 immediately (async). After release, the next window_done reports only edges since release (period 4, 6_000 clk → 1500 ±1).
